// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N:1 selector with stall/flush-aware output stage,
// round-robin scan mode and out-of-range select detection.

// One selector lane: passes its input through only when the select hits it.
module mux_sel_lane #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3,
    parameter int IDX   = 0
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dout
);
    assign dout = (sel == SEL_W'(IDX)) ? din : '0;
endmodule

module mux_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN*WIDTH-1:0]   in_bus,
    input  logic [$clog2(NUM_IN)-1:0] addr,
    input  logic                      mode,
    input  logic                      in_valid,
    input  logic                      mask,
    input  logic                      stall,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [$clog2(NUM_IN)-1:0] out_sel,
    output logic                      addr_err,
    output logic [$clog2(NUM_IN)-1:0] rr_ptr
);
    localparam int SEL_W = $clog2(NUM_IN);
    // NUM_IN needs one more bit than an index when NUM_IN is a power of two
    localparam logic [SEL_W:0]   NUM_IN_C = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] RR_LAST  = SEL_W'(NUM_IN - 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             vld;
        logic [SEL_W-1:0] sel;
        logic             err;
    } rsp_t;

    logic [NUM_IN-1:0][WIDTH-1:0] lane_q;
    logic [WIDTH-1:0]             pick;
    logic [SEL_W-1:0]             sel;
    logic                         in_range;
    logic                         ld;
    logic                         rr_adv;
    logic [SEL_W-1:0]             rr_nxt;
    logic [SEL_W-1:0]             rr_q;
    rsp_t                         rsp_q;
    rsp_t                         rsp_d;

    assign sel      = mode ? rr_q : addr;
    assign in_range = {1'b0, sel} < NUM_IN_C;
    assign ld       = !flush && !stall;
    assign rr_adv   = ld && mode && in_valid && !mask;
    assign rr_nxt   = (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;

    // One-hot AND-OR select; an out-of-range index matches no lane and yields 0
    genvar k;
    generate
        for (k = 0; k < NUM_IN; k++) begin : g_lane
            mux_sel_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
                .din  (in_bus[k*WIDTH +: WIDTH]),
                .sel  (sel),
                .dout (lane_q[k])
            );
        end
    endgenerate

    // OR-reduce the lane outputs into the selected word
    always_comb begin
        pick = '0;
        for (int i = 0; i < NUM_IN; i++) pick |= lane_q[i];
    end

    // Next output-stage contents on a load; data/sel captured regardless of in_valid
    always_comb begin
        rsp_d      = '0;
        rsp_d.data = (mask || !in_range) ? '0 : pick;
        rsp_d.vld  = in_valid && !mask && in_range;
        rsp_d.sel  = sel;
        rsp_d.err  = in_valid && !mask && !in_range;
    end

    // Output stage: flush clears, stall holds everything including the error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rsp_q <= '0;
        else if (flush) rsp_q <= '0;
        else if (ld)    rsp_q <= rsp_d;
    end

    // Round-robin pointer: steps only on an accepted, unmasked round-robin request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_q <= '0;
        else if (flush)  rr_q <= '0;
        else if (rr_adv) rr_q <= rr_nxt;
    end

    assign out       = rsp_q.data;
    assign out_valid = rsp_q.vld;
    assign out_sel   = rsp_q.sel;
    assign addr_err  = rsp_q.err;
    assign rr_ptr    = rr_q;
endmodule
